cascade_sequencer: RTL and testbench

Control FSM that sequences the Haar-cascade evaluation of one integral-image window for `top_level_classifier`. It accepts a window from the image loader and walks the stage table stage by stage. For each stage it issues each weak-classifier feature to the feature evaluator, accumulates the signed votes and compares the sum against the stage threshold. It stops at the first failing stage, then reports `face_status` and requests the next window.

---
 rtl/cascade_sequencer_if.sv | 32 +++
 rtl/cascade_sequencer.sv | 144 ++++++++++++++
 tb/tb_cascade_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cascade_sequencer_if.sv
// rtl/cascade_sequencer_if.sv - window handshake, stage ROM, feature evaluator and result bus
interface cascade_sequencer_if #(
    parameter int STAGE_AW = 5,
    parameter int FEAT_AW  = 12,
    parameter int CNT_W    = 8,
    parameter int SUM_W    = 16
);
    logic                win_valid;
    logic                request_new_data;
    logic [STAGE_AW-1:0] stage_idx;
    logic [CNT_W-1:0]    stage_count;
    logic [SUM_W-1:0]    stage_thresh;
    logic [FEAT_AW-1:0]  feat_addr;
    logic                feat_start;
    logic                feat_done;
    logic [SUM_W-1:0]    feat_vote;
    logic                busy;
    logic                result_valid;
    logic                face_status;

    modport master (
        input  win_valid, stage_count, stage_thresh, feat_done, feat_vote,
        output request_new_data, stage_idx, feat_addr, feat_start,
               busy, result_valid, face_status
    );

    modport slave (
        output win_valid, stage_count, stage_thresh, feat_done, feat_vote,
        input  request_new_data, stage_idx, feat_addr, feat_start,
               busy, result_valid, face_status
    );
endinterface

// File: rtl/cascade_sequencer.sv
// rtl/cascade_sequencer.sv - Haar-cascade stage/feature sequencer for one integral-image window
// Walks the stage table, accumulates saturating signed votes, stops at the first failing stage.
module cascade_sequencer #(
    parameter int NUM_STAGES = 25,
    parameter int STAGE_AW   = 5,
    parameter int FEAT_AW    = 12,
    parameter int CNT_W      = 8,
    parameter int SUM_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    cascade_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        STAGE_LOAD,
        FEAT_ISSUE,
        FEAT_WAIT,
        STAGE_EVAL,
        DONE
    } state_t;

    localparam logic [STAGE_AW-1:0]    LAST_STAGE = STAGE_AW'(NUM_STAGES - 1);
    localparam logic [STAGE_AW-1:0]    STAGE_ONE  = STAGE_AW'(1);
    localparam logic [FEAT_AW-1:0]     FEAT_ONE   = FEAT_AW'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic signed [SUM_W-1:0] SUM_MAX   = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN   = {1'b1, {(SUM_W-1){1'b0}}};

    state_t                  state, state_n;
    logic [CNT_W-1:0]        feat_cnt, count_q;
    logic signed [SUM_W-1:0] acc, thresh_q, pend_vote, vote_eff, acc_sat;
    logic signed [SUM_W:0]   sum_wide;
    logic                    pend_valid, done_eff, accept, last_feat, reject, last_stage;

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        // a vote parked during a stall takes precedence over the live bus
        done_eff   = pend_valid | bus.feat_done;
        vote_eff   = pend_valid ? pend_vote : $signed(bus.feat_vote);
        last_feat  = (feat_cnt == count_q - CNT_ONE);
        reject     = (acc < thresh_q);
        last_stage = (bus.stage_idx == LAST_STAGE);
        sum_wide   = {acc[SUM_W-1], acc} + {vote_eff[SUM_W-1], vote_eff};
        if (sum_wide[SUM_W] != sum_wide[SUM_W-1]) begin
            acc_sat = sum_wide[SUM_W] ? SUM_MIN : SUM_MAX;
        end else begin
            acc_sat = sum_wide[SUM_W-1:0];
        end

        if (en) begin
            case (state)
                IDLE: begin
                    if (bus.win_valid && bus.request_new_data) begin
                        accept  = 1'b1;
                        state_n = STAGE_LOAD;
                    end
                end
                STAGE_LOAD: state_n = (bus.stage_count == '0) ? STAGE_EVAL : FEAT_ISSUE;
                FEAT_ISSUE: state_n = FEAT_WAIT;
                FEAT_WAIT: begin
                    if (done_eff) begin
                        state_n = last_feat ? STAGE_EVAL : FEAT_ISSUE;
                    end
                end
                STAGE_EVAL: state_n = (reject || last_stage) ? DONE : STAGE_LOAD;
                DONE:       state_n = IDLE;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            bus.request_new_data <= 1'b0;
            bus.busy             <= 1'b0;
            bus.feat_start       <= 1'b0;
            bus.result_valid     <= 1'b0;
            bus.face_status      <= 1'b0;
            bus.stage_idx        <= '0;
            bus.feat_addr        <= '0;
            feat_cnt             <= '0;
            count_q              <= '0;
            thresh_q             <= '0;
            acc                  <= '0;
            pend_valid           <= 1'b0;
            pend_vote            <= '0;
        end else begin
            state                <= state_n;
            bus.request_new_data <= en && (state_n == IDLE);
            bus.busy             <= (state_n != IDLE);
            bus.feat_start       <= en && (state_n == FEAT_ISSUE);
            bus.result_valid     <= en && (state_n == DONE);

            if (!en && state == FEAT_WAIT && bus.feat_done && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_vote  <= $signed(bus.feat_vote);
            end

            if (en) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            bus.stage_idx <= '0;
                            bus.feat_addr <= '0;
                            feat_cnt      <= '0;
                            acc           <= '0;
                            pend_valid    <= 1'b0;
                        end
                    end
                    STAGE_LOAD: begin
                        count_q  <= bus.stage_count;
                        thresh_q <= $signed(bus.stage_thresh);
                        acc      <= '0;
                        feat_cnt <= '0;
                    end
                    FEAT_WAIT: begin
                        if (done_eff) begin
                            acc           <= acc_sat;
                            bus.feat_addr <= bus.feat_addr + FEAT_ONE;
                            pend_valid    <= 1'b0;
                            if (!last_feat) begin
                                feat_cnt <= feat_cnt + CNT_ONE;
                            end
                        end
                    end
                    STAGE_EVAL: begin
                        if (reject) begin
                            bus.face_status <= 1'b0;
                        end else if (last_stage) begin
                            bus.face_status <= 1'b1;
                        end else begin
                            bus.stage_idx <= bus.stage_idx + STAGE_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cascade_sequencer.sv
// tb/tb_cascade_sequencer.sv - directed self-checking bench for cascade_sequencer
module tb_cascade_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    cascade_sequencer_if #(.STAGE_AW(5), .FEAT_AW(12), .CNT_W(8), .SUM_W(16)) b1 ();
    cascade_sequencer_if #(.STAGE_AW(5), .FEAT_AW(12), .CNT_W(8), .SUM_W(8))  b2 ();

    cascade_sequencer #(.NUM_STAGES(3), .STAGE_AW(5), .FEAT_AW(12), .CNT_W(8), .SUM_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .bus(b1)
    );
    cascade_sequencer #(.NUM_STAGES(1), .STAGE_AW(5), .FEAT_AW(12), .CNT_W(8), .SUM_W(8)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .bus(b2)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int rel, n_start, res_cycle, n_results, max_stage, res2_cycle;
    int cd1, cd2, cur1, cur2, stall_left, stall_addr;
    bit stall_armed;
    logic res_face, res2_face, rnd_after;
    logic [11:0] addr_log [0:15];
    logic [7:0] counts [0:3];
    logic signed [15:0] thr [0:3];
    logic signed [15:0] votes [0:15];
    logic signed [7:0] votes2 [0:1];
    logic signed [7:0] thr2;

    // One clock: observe outputs #1 after the edge, then drive ROM/evaluator inputs for this cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        rel++;
        if (int'(b1.stage_idx) > max_stage) max_stage = int'(b1.stage_idx);
        if (b1.result_valid) begin
            n_results++;
            if (res_cycle < 0) begin res_cycle = rel; res_face = b1.face_status; end
        end
        if (b2.result_valid && res2_cycle < 0) begin res2_cycle = rel; res2_face = b2.face_status; end

        if (stall_left > 0) begin stall_left--; en = 1'b0; end
        else en = 1'b1;

        b1.feat_done = 1'b0;
        if (cd1 > 0) begin
            cd1--;
            if (cd1 == 0) begin
                b1.feat_done = 1'b1;
                b1.feat_vote = votes[cur1];
                if (stall_armed && cur1 == stall_addr) begin
                    stall_armed = 1'b0;
                    en = 1'b0;
                    stall_left = 3;
                end
            end
        end
        if (b1.feat_start) begin
            if (n_start < 16) addr_log[n_start] = b1.feat_addr;
            n_start++;
            cd1 = 2;
            cur1 = int'(b1.feat_addr[3:0]);
        end

        b2.feat_done = 1'b0;
        if (cd2 > 0) begin
            cd2--;
            if (cd2 == 0) begin b2.feat_done = 1'b1; b2.feat_vote = votes2[cur2]; end
        end
        if (b2.feat_start) begin cd2 = 2; cur2 = int'(b2.feat_addr[0]); end

        b1.stage_count  = counts[b1.stage_idx[1:0]];
        b1.stage_thresh = thr[b1.stage_idx[1:0]];
        b2.stage_count  = 8'd2;
        b2.stage_thresh = thr2;
    endtask

    task automatic set_default();
        counts[0] = 8'd2; counts[1] = 8'd3; counts[2] = 8'd1; counts[3] = 8'd0;
        thr[0] = 16'sd15; thr[1] = 16'sd25; thr[2] = 16'sd5; thr[3] = 16'sd0;
        for (int i = 0; i < 16; i++) votes[i] = 16'sd10;
    endtask

    task automatic run_window1();
        int k;
        k = 0;
        while (!b1.request_new_data && k < 20) begin cyc(); k++; end
        rel = 0; n_start = 0; max_stage = 0; res_cycle = -1; n_results = 0;
        for (int i = 0; i < 16; i++) addr_log[i] = 12'hfff;
        b1.win_valid = 1'b1;
        cyc();
        b1.win_valid = 1'b0;
        while (res_cycle < 0 && rel < 80) cyc();
        cyc();
        rnd_after = b1.request_new_data;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            b1.win_valid = i[0];
            cyc();
            tests_run++;
            if ({b1.request_new_data, b1.busy, b1.feat_start, b1.result_valid, b1.face_status} !== 5'b0
                || b1.stage_idx !== 5'd0 || b1.feat_addr !== 12'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: rnd=%b busy=%b fs=%b rv=%b face=%b stage=%0d addr=%0d, want all 0",
                         i, b1.request_new_data, b1.busy, b1.feat_start, b1.result_valid,
                         b1.face_status, b1.stage_idx, b1.feat_addr);
            end
        end
        b1.win_valid = 1'b0;
        rst = 1'b1;
        tests_run++;
        if (b1.request_new_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_pre got rnd=%b want 0", b1.request_new_data);
        end
        cyc();
        tests_run++;
        if (b1.request_new_data !== 1'b1 || b1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_edge got rnd=%b busy=%b want 1 0", b1.request_new_data, b1.busy);
        end
    endtask

    task automatic test_full_pass();
        set_default();
        run_window1();
        tests_run++;
        if (res_cycle !== 25 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pass_result got cycle=%0d face=%b want 25 1", res_cycle, res_face);
        end
        tests_run++;
        if (rnd_after !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pass_rnd got %b want 1 in cycle 26", rnd_after);
        end
        tests_run++;
        if (n_start !== 6 || max_stage !== 2 || n_results !== 1) begin
            tests_failed++;
            $display("FAIL full_pass_counts got starts=%0d max_stage=%0d results=%0d want 6 2 1",
                     n_start, max_stage, n_results);
        end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (addr_log[i] !== 12'(i)) begin
                tests_failed++;
                $display("FAIL full_pass_addr[%0d] got %0d want %0d", i, addr_log[i], i);
            end
        end
    endtask

    task automatic test_early_reject();
        set_default();
        votes[2] = -16'sd5; votes[3] = -16'sd5; votes[4] = -16'sd5;
        run_window1();
        tests_run++;
        if (res_cycle !== 20 || res_face !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_reject_result got cycle=%0d face=%b want 20 0", res_cycle, res_face);
        end
        tests_run++;
        if (n_start !== 5 || max_stage !== 1) begin
            tests_failed++;
            $display("FAIL early_reject_extent got starts=%0d max_stage=%0d want 5 1", n_start, max_stage);
        end
    endtask

    task automatic test_back_to_back();
        set_default();
        run_window1();
        tests_run++;
        if (addr_log[0] !== 12'd0 || res_cycle !== 25 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back got first_addr=%0d cycle=%0d face=%b want 0 25 1",
                     addr_log[0], res_cycle, res_face);
        end
    endtask

    task automatic test_boundary_eq();
        set_default();
        votes[0] = 16'sd7; votes[1] = 16'sd8;
        run_window1();
        tests_run++;
        if (res_cycle !== 25 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL thresh_equal got cycle=%0d face=%b want 25 1", res_cycle, res_face);
        end
        votes[1] = 16'sd7;
        run_window1();
        tests_run++;
        if (res_cycle !== 9 || res_face !== 1'b0 || n_start !== 2) begin
            tests_failed++;
            $display("FAIL thresh_below got cycle=%0d face=%b starts=%0d want 9 0 2",
                     res_cycle, res_face, n_start);
        end
    endtask

    task automatic test_count_zero();
        set_default();
        counts[1] = 8'd0; thr[1] = 16'sd0;
        run_window1();
        tests_run++;
        if (res_cycle !== 16 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_zero_result got cycle=%0d face=%b want 16 1", res_cycle, res_face);
        end
        tests_run++;
        if (n_start !== 3 || addr_log[2] !== 12'd2 || max_stage !== 2) begin
            tests_failed++;
            $display("FAIL count_zero_feats got starts=%0d addr2=%0d max_stage=%0d want 3 2 2",
                     n_start, addr_log[2], max_stage);
        end
    endtask

    task automatic test_stall();
        set_default();
        votes[0] = 16'sd7; votes[1] = 16'sd8;
        stall_armed = 1'b1; stall_addr = 1;
        run_window1();
        tests_run++;
        if (res_cycle !== 29 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_result got cycle=%0d face=%b want 29 1", res_cycle, res_face);
        end
        tests_run++;
        if (n_start !== 6 || n_results !== 1 || stall_armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_counts got starts=%0d results=%0d armed=%b want 6 1 0",
                     n_start, n_results, stall_armed);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        set_default();
        k = 0;
        while (!b1.request_new_data && k < 20) begin cyc(); k++; end
        rel = 0; n_results = 0; res_cycle = -1;
        b1.win_valid = 1'b1;
        cyc();
        b1.win_valid = 1'b0;
        while (rel < 12) cyc();
        tests_run++;
        if (b1.stage_idx !== 5'd1 || b1.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_setup got stage=%0d busy=%b want 1 1", b1.stage_idx, b1.busy);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({b1.request_new_data, b1.busy, b1.feat_start, b1.result_valid, b1.face_status} !== 5'b0
            || b1.stage_idx !== 5'd0 || b1.feat_addr !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs got busy=%b face=%b stage=%0d addr=%0d want all 0",
                     b1.busy, b1.face_status, b1.stage_idx, b1.feat_addr);
        end
        for (int i = 0; i < 3; i++) cyc();
        tests_run++;
        if (n_results !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_result got %0d results want 0", n_results);
        end
        cd1 = 0;
        b1.feat_done = 1'b0;
        rst = 1'b1;
        run_window1();
        tests_run++;
        if (addr_log[0] !== 12'd0 || res_cycle !== 25 || res_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart got first_addr=%0d cycle=%0d face=%b want 0 25 1",
                     addr_log[0], res_cycle, res_face);
        end
    endtask

    task automatic run_window2();
        int k;
        k = 0;
        while (!b2.request_new_data && k < 20) begin cyc(); k++; end
        rel = 0; res2_cycle = -1;
        b2.win_valid = 1'b1;
        cyc();
        b2.win_valid = 1'b0;
        while (res2_cycle < 0 && rel < 40) cyc();
    endtask

    task automatic test_saturation();
        thr2 = 8'sd127;
        votes2[0] = 8'sd100; votes2[1] = 8'sd100;
        run_window2();
        tests_run++;
        if (res2_cycle !== 9 || res2_face !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturate_pos got cycle=%0d face=%b want 9 1", res2_cycle, res2_face);
        end
        votes2[1] = -8'sd100;
        run_window2();
        tests_run++;
        if (res2_cycle !== 9 || res2_face !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_signed_sum got cycle=%0d face=%b want 9 0", res2_cycle, res2_face);
        end
    endtask

    initial begin
        b1.win_valid = 1'b0; b1.feat_done = 1'b0; b1.feat_vote = '0;
        b1.stage_count = '0; b1.stage_thresh = '0;
        b2.win_valid = 1'b0; b2.feat_done = 1'b0; b2.feat_vote = '0;
        b2.stage_count = '0; b2.stage_thresh = '0;
        cd1 = 0; cd2 = 0; cur1 = 0; cur2 = 0; stall_left = 0; stall_armed = 1'b0; stall_addr = 0;
        rel = 0; n_start = 0; res_cycle = -1; n_results = 0; max_stage = 0; res2_cycle = -1;
        res_face = 1'b0; res2_face = 1'b0; rnd_after = 1'b0;
        thr2 = 8'sd127; votes2[0] = 8'sd0; votes2[1] = 8'sd0;
        set_default();
        #1 rst = 1'b0;
        test_reset();
        test_full_pass();
        test_early_reject();
        test_back_to_back();
        test_boundary_eq();
        test_count_zero();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1);
    end
endmodule
